// File: rtl/gcd_arb_pkg.sv
// Shared types and defaults for the GCD engine arbiter.
// Optional WAIT timeout is enabled by GCD_ARB_TIMEOUT_EN.
package gcd_arb_pkg;

  localparam int W_DEF       = 16;
  localparam int TIMEOUT_DEF = 1023;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/gcd_arbiter_if.sv
// Requester, response and engine handshakes of gcd_arbiter.
// slave = arbiter side, master = environment side.
interface gcd_arbiter_if #(
  parameter int W = 16
);

  logic         io_req0_valid;
  logic         io_req0_ready;
  logic [W-1:0] io_req0_bits_a;
  logic [W-1:0] io_req0_bits_b;
  logic         io_req1_valid;
  logic         io_req1_ready;
  logic [W-1:0] io_req1_bits_a;
  logic [W-1:0] io_req1_bits_b;

  logic         io_resp0_valid;
  logic         io_resp0_ready;
  logic [W-1:0] io_resp0_bits;
  logic         io_resp0_err;
  logic         io_resp1_valid;
  logic         io_resp1_ready;
  logic [W-1:0] io_resp1_bits;
  logic         io_resp1_err;

  logic         io_gcd_in_valid;
  logic         io_gcd_in_ready;
  logic [W-1:0] io_gcd_in_bits_a;
  logic [W-1:0] io_gcd_in_bits_b;
  logic         io_gcd_out_valid;
  logic [W-1:0] io_gcd_out_bits;

  logic         io_busy;

  modport slave (
    input  io_req0_valid, io_req0_bits_a, io_req0_bits_b,
    input  io_req1_valid, io_req1_bits_a, io_req1_bits_b,
    output io_req0_ready, io_req1_ready,
    input  io_resp0_ready, io_resp1_ready,
    output io_resp0_valid, io_resp0_bits, io_resp0_err,
    output io_resp1_valid, io_resp1_bits, io_resp1_err,
    output io_gcd_in_valid, io_gcd_in_bits_a, io_gcd_in_bits_b,
    input  io_gcd_in_ready,
    input  io_gcd_out_valid, io_gcd_out_bits,
    output io_busy
  );

  modport master (
    output io_req0_valid, io_req0_bits_a, io_req0_bits_b,
    output io_req1_valid, io_req1_bits_a, io_req1_bits_b,
    input  io_req0_ready, io_req1_ready,
    output io_resp0_ready, io_resp1_ready,
    input  io_resp0_valid, io_resp0_bits, io_resp0_err,
    input  io_resp1_valid, io_resp1_bits, io_resp1_err,
    input  io_gcd_in_valid, io_gcd_in_bits_a, io_gcd_in_bits_b,
    output io_gcd_in_ready,
    output io_gcd_out_valid, io_gcd_out_bits,
    input  io_busy
  );

endinterface

// File: rtl/gcd_rr_arbiter.sv
// Two-way round-robin grant; requester 0 wins ties after reset.
// The pointer moves only when a grant is actually taken.
module gcd_rr_arbiter (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_elig,
  input  logic       i_take,
  output logic [1:0] o_grant
);

  // requester that wins when both are eligible
  logic r_prio;

  // grant: tie goes to r_prio, otherwise the lone eligible one
  always_comb begin
    o_grant = i_elig;
    if (i_elig == 2'b11) begin
      o_grant = r_prio ? 2'b10 : 2'b01;
    end
  end

  // pointer: after serving 0, 1 gets the next tie, and vice versa
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prio <= 1'b0;
    end else if (i_take) begin
      r_prio <= o_grant[0];
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// Shares one GCD engine between two requesters, one job at a time.
// Define GCD_ARB_TIMEOUT_EN to abort silent engine jobs in WAIT.
module gcd_arbiter
  import gcd_arb_pkg::*;
#(
  parameter int W              = W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input logic          clock,
  input logic          reset,
  gcd_arbiter_if.slave bus
);

  state_t       r_state;
  state_t       w_next;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic         r_owner;
  logic [1:0]   r_rv;
  logic [W-1:0] r_rb [2];

  logic [1:0]   w_elig;
  logic [1:0]   w_grant;
  logic [1:0]   w_ready;
  logic [1:0]   w_rrdy;
  logic         w_take;
  logic         w_done;
  logic         w_tmo;
  logic         w_fin;

  assign w_elig[0] = bus.io_req0_valid & ~r_rv[0];
  assign w_elig[1] = bus.io_req1_valid & ~r_rv[1];
  assign w_rrdy    = {bus.io_resp1_ready, bus.io_resp0_ready};

  gcd_rr_arbiter u_rr (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_elig  (w_elig),
    .i_take  (w_take),
    .o_grant (w_grant)
  );

  // ready only in IDLE; reset masks the combinational path
  assign w_ready = (r_state == S_IDLE && reset) ? w_grant : 2'b00;
  assign w_take  = |w_ready;
  assign w_fin   = w_done | w_tmo;

`ifdef GCD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_re;

  // counts WAIT cycles of the current job
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (r_state != S_WAIT) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // error flag travels with the owner's response
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_re <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_fin && (r_owner == 1'(i))) begin
          r_re[i] <= w_tmo;
        end
      end
    end
  end

  assign bus.io_resp0_err = r_re[0];
  assign bus.io_resp1_err = r_re[1];
`else
  assign bus.io_resp0_err = 1'b0;
  assign bus.io_resp1_err = 1'b0;
`endif

  // state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next state; engine results outside WAIT are ignored
  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    w_tmo  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_take) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (bus.io_gcd_in_ready) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (bus.io_gcd_out_valid) begin
          w_done = 1'b1;
          w_next = S_IDLE;
        end
`ifdef GCD_ARB_TIMEOUT_EN
        else if (r_cnt == CNT_MAX) begin
          w_tmo  = 1'b1;
          w_next = S_IDLE;
        end
`endif
      end
      default: w_next = S_IDLE;
    endcase
  end

  // capture operands and owner on accept
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_owner <= 1'b0;
    end else if (w_take) begin
      r_owner <= w_ready[1];
      r_a     <= w_ready[1] ? bus.io_req1_bits_a
                            : bus.io_req0_bits_a;
      r_b     <= w_ready[1] ? bus.io_req1_bits_b
                            : bus.io_req0_bits_b;
    end
  end

  // response registers: load on finish, drop valid on ready
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rv <= '0;
      for (int i = 0; i < 2; i++) r_rb[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_fin && (r_owner == 1'(i))) begin
          r_rv[i] <= 1'b1;
          r_rb[i] <= w_tmo ? '0 : bus.io_gcd_out_bits;
        end else if (r_rv[i] && w_rrdy[i]) begin
          r_rv[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.io_req0_ready    = w_ready[0];
  assign bus.io_req1_ready    = w_ready[1];
  assign bus.io_resp0_valid   = r_rv[0];
  assign bus.io_resp1_valid   = r_rv[1];
  assign bus.io_resp0_bits    = r_rb[0];
  assign bus.io_resp1_bits    = r_rb[1];
  assign bus.io_gcd_in_valid  = (r_state == S_ISSUE);
  assign bus.io_gcd_in_bits_a = r_a;
  assign bus.io_gcd_in_bits_b = r_b;
  assign bus.io_busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed bench for gcd_arbiter; the bench plays the GCD engine.
// Timeout scenario is built when GCD_ARB_TIMEOUT_EN is defined.
module tb_gcd_arbiter;

`ifdef GCD_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1023;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  gcd_arbiter_if #(.W(16)) bus ();

  gcd_arbiter #(
    .W              (16),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  // engine accepts the job at once and answers in the first WAIT cycle
  task automatic engine(input logic [15:0] r);
    bus.io_gcd_in_ready = 1'b1;
    tick();
    bus.io_gcd_in_ready  = 1'b0;
    bus.io_gcd_out_valid = 1'b1;
    bus.io_gcd_out_bits  = r;
    tick();
    bus.io_gcd_out_valid = 1'b0;
    bus.io_gcd_out_bits  = 16'hdead;
  endtask

  task automatic test_reset();
    bus.io_req0_valid    = 1'b0;
    bus.io_req1_valid    = 1'b0;
    bus.io_req0_bits_a   = '0;
    bus.io_req0_bits_b   = '0;
    bus.io_req1_bits_a   = '0;
    bus.io_req1_bits_b   = '0;
    bus.io_resp0_ready   = 1'b0;
    bus.io_resp1_ready   = 1'b0;
    bus.io_gcd_in_ready  = 1'b0;
    bus.io_gcd_out_valid = 1'b0;
    bus.io_gcd_out_bits  = '0;
    reset = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (bus.io_busy !== 1'b0) begin
      n_bad++; $display("FAIL rst_busy: got %b want 0", bus.io_busy);
    end
    n_cmp++;
    if ({bus.io_resp0_valid, bus.io_resp1_valid, bus.io_gcd_in_valid} !== 3'b000) begin
      n_bad++; $display("FAIL rst_valids: got %b%b%b want 000",
        bus.io_resp0_valid, bus.io_resp1_valid, bus.io_gcd_in_valid);
    end
    n_cmp++;
    if ({bus.io_resp0_bits, bus.io_resp1_bits} !== 32'h0) begin
      n_bad++; $display("FAIL rst_bits: got %h %h want 0 0",
        bus.io_resp0_bits, bus.io_resp1_bits);
    end
    n_cmp++;
    if ({bus.io_resp0_err, bus.io_resp1_err, bus.io_req0_ready, bus.io_req1_ready} !== 4'b0) begin
      n_bad++; $display("FAIL rst_err_rdy: got %b%b%b%b want 0000", bus.io_resp0_err,
        bus.io_resp1_err, bus.io_req0_ready, bus.io_req1_ready);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bus.io_req0_valid  = 1'b1;
    bus.io_req0_bits_a = 16'd48;
    bus.io_req0_bits_b = 16'd32;
    #1;
    n_cmp++;
    if ({bus.io_req0_ready, bus.io_req1_ready} !== 2'b10) begin
      n_bad++; $display("FAIL single_ready: got %b%b want 10",
        bus.io_req0_ready, bus.io_req1_ready);
    end
    tick();
    bus.io_req0_valid = 1'b0;
    n_cmp++;
    if ({bus.io_gcd_in_valid, bus.io_busy} !== 2'b11 ||
        bus.io_gcd_in_bits_a !== 16'd48 || bus.io_gcd_in_bits_b !== 16'd32) begin
      n_bad++; $display("FAIL single_issue: got v=%b a=%0d b=%0d want v=1 a=48 b=32",
        bus.io_gcd_in_valid, bus.io_gcd_in_bits_a, bus.io_gcd_in_bits_b);
    end
    engine(16'd16);
    n_cmp++;
    if ({bus.io_resp0_valid, bus.io_resp0_err} !== 2'b10 || bus.io_resp0_bits !== 16'd16) begin
      n_bad++; $display("FAIL single_resp: got v=%b e=%b d=%0d want v=1 e=0 d=16",
        bus.io_resp0_valid, bus.io_resp0_err, bus.io_resp0_bits);
    end
    n_cmp++;
    if ({bus.io_resp1_valid, bus.io_busy} !== 2'b00) begin
      n_bad++; $display("FAIL single_other: got r1v=%b busy=%b want 0 0",
        bus.io_resp1_valid, bus.io_busy);
    end
    bus.io_resp0_ready = 1'b1;
    tick();
    bus.io_resp0_ready = 1'b0;
    n_cmp++;
    if (bus.io_resp0_valid !== 1'b0) begin
      n_bad++; $display("FAIL single_clear: got %b want 0", bus.io_resp0_valid);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.io_req0_valid  = 1'b1;
    bus.io_req0_bits_a = 16'd7;
    bus.io_req0_bits_b = 16'd3;
    bus.io_req1_valid  = 1'b1;
    bus.io_req1_bits_a = 16'd100;
    bus.io_req1_bits_b = 16'd10;
    #1;
    n_cmp++;
    if ({bus.io_req0_ready, bus.io_req1_ready} !== 2'b10) begin
      n_bad++; $display("FAIL rr_first: got %b%b want 10",
        bus.io_req0_ready, bus.io_req1_ready);
    end
    tick();
    bus.io_req0_valid = 1'b0;
    n_cmp++;
    if (bus.io_gcd_in_bits_a !== 16'd7 || bus.io_gcd_in_bits_b !== 16'd3) begin
      n_bad++; $display("FAIL rr_ops0: got %0d,%0d want 7,3",
        bus.io_gcd_in_bits_a, bus.io_gcd_in_bits_b);
    end
    engine(16'd1);
    bus.io_resp0_ready = 1'b1;
    #1;
    n_cmp++;
    if (bus.io_resp0_bits !== 16'd1 || bus.io_req1_ready !== 1'b1) begin
      n_bad++; $display("FAIL rr_resp0: got d=%0d r1rdy=%b want d=1 r1rdy=1",
        bus.io_resp0_bits, bus.io_req1_ready);
    end
    tick();
    bus.io_req1_valid  = 1'b0;
    bus.io_resp0_ready = 1'b0;
    n_cmp++;
    if (bus.io_resp0_valid !== 1'b0 || bus.io_gcd_in_bits_a !== 16'd100 ||
        bus.io_gcd_in_bits_b !== 16'd10) begin
      n_bad++; $display("FAIL rr_ops1: got r0v=%b a=%0d b=%0d want 0 100 10",
        bus.io_resp0_valid, bus.io_gcd_in_bits_a, bus.io_gcd_in_bits_b);
    end
    engine(16'd10);
    n_cmp++;
    if (bus.io_resp1_valid !== 1'b1 || bus.io_resp1_bits !== 16'd10) begin
      n_bad++; $display("FAIL rr_resp1: got v=%b d=%0d want v=1 d=10",
        bus.io_resp1_valid, bus.io_resp1_bits);
    end
    bus.io_resp1_ready = 1'b1;
    tick();
    bus.io_resp1_ready = 1'b0;
    bus.io_req0_valid  = 1'b1;
    bus.io_req0_bits_a = 16'd12;
    bus.io_req0_bits_b = 16'd8;
    bus.io_req1_valid  = 1'b1;
    bus.io_req1_bits_a = 16'd21;
    bus.io_req1_bits_b = 16'd14;
    #1;
    n_cmp++;
    if ({bus.io_req0_ready, bus.io_req1_ready} !== 2'b10) begin
      n_bad++; $display("FAIL rr_alt0: got %b%b want 10",
        bus.io_req0_ready, bus.io_req1_ready);
    end
    tick();
    bus.io_req0_valid = 1'b0;
    bus.io_req1_valid = 1'b0;
    engine(16'd4);
    bus.io_resp0_ready = 1'b1;
    tick();
    bus.io_resp0_ready = 1'b0;
    bus.io_req0_valid  = 1'b1;
    bus.io_req1_valid  = 1'b1;
    #1;
    n_cmp++;
    if ({bus.io_req0_ready, bus.io_req1_ready} !== 2'b01) begin
      n_bad++; $display("FAIL rr_alt1: got %b%b want 01",
        bus.io_req0_ready, bus.io_req1_ready);
    end
    tick();
    bus.io_req0_valid = 1'b0;
    bus.io_req1_valid = 1'b0;
    engine(16'd7);
    n_cmp++;
    if (bus.io_resp1_bits !== 16'd7 || bus.io_resp0_bits !== 16'd4) begin
      n_bad++; $display("FAIL rr_alt_bits: got r1=%0d r0=%0d want 7 4",
        bus.io_resp1_bits, bus.io_resp0_bits);
    end
    bus.io_resp1_ready = 1'b1;
    tick();
    bus.io_resp1_ready = 1'b0;
  endtask

  task automatic test_hold();
    bus.io_req0_valid  = 1'b1;
    bus.io_req0_bits_a = 16'd48;
    bus.io_req0_bits_b = 16'd18;
    tick();
    bus.io_req0_bits_a = 16'd10;
    bus.io_req0_bits_b = 16'd4;
    engine(16'd6);
    for (int i = 0; i < 20; i++) begin
      n_cmp++;
      if (bus.io_req0_ready !== 1'b0) begin
        n_bad++; $display("FAIL hold_rdy[%0d]: got %b want 0", i, bus.io_req0_ready);
      end
      n_cmp++;
      if (bus.io_resp0_valid !== 1'b1 || bus.io_resp0_bits !== 16'd6) begin
        n_bad++; $display("FAIL hold_resp[%0d]: got v=%b d=%0d want v=1 d=6",
          i, bus.io_resp0_valid, bus.io_resp0_bits);
      end
      if (i == 5) begin
        bus.io_gcd_out_valid = 1'b1;
        bus.io_gcd_out_bits  = 16'd99;
      end
      tick();
      bus.io_gcd_out_valid = 1'b0;
    end
    bus.io_resp0_ready = 1'b1;
    tick();
    bus.io_resp0_ready = 1'b0;
    #1;
    n_cmp++;
    if ({bus.io_resp0_valid, bus.io_req0_ready} !== 2'b01) begin
      n_bad++; $display("FAIL hold_release: got v=%b rdy=%b want 0 1",
        bus.io_resp0_valid, bus.io_req0_ready);
    end
    tick();
    bus.io_req0_valid = 1'b0;
    engine(16'd2);
    n_cmp++;
    if (bus.io_resp0_bits !== 16'd2) begin
      n_bad++; $display("FAIL hold_next: got %0d want 2", bus.io_resp0_bits);
    end
    bus.io_resp0_ready = 1'b1;
    tick();
    bus.io_resp0_ready = 1'b0;
  endtask

  task automatic test_stall();
    bus.io_req1_valid  = 1'b1;
    bus.io_req1_bits_a = 16'd0;
    bus.io_req1_bits_b = 16'd25;
    tick();
    bus.io_req1_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({bus.io_gcd_in_valid, bus.io_busy} !== 2'b11 ||
          bus.io_gcd_in_bits_a !== 16'd0 || bus.io_gcd_in_bits_b !== 16'd25) begin
        n_bad++; $display("FAIL stall[%0d]: got v=%b busy=%b a=%0d b=%0d want 1 1 0 25",
          i, bus.io_gcd_in_valid, bus.io_busy,
          bus.io_gcd_in_bits_a, bus.io_gcd_in_bits_b);
      end
      tick();
    end
    engine(16'd25);
    n_cmp++;
    if ({bus.io_resp1_valid, bus.io_busy} !== 2'b10 || bus.io_resp1_bits !== 16'd25) begin
      n_bad++; $display("FAIL stall_resp: got v=%b busy=%b d=%0d want 1 0 25",
        bus.io_resp1_valid, bus.io_busy, bus.io_resp1_bits);
    end
    bus.io_resp1_ready = 1'b1;
    tick();
    bus.io_resp1_ready = 1'b0;
  endtask

`ifdef GCD_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bus.io_req0_valid  = 1'b1;
    bus.io_req0_bits_a = 16'd5;
    bus.io_req0_bits_b = 16'd0;
    tick();
    bus.io_req0_valid   = 1'b0;
    bus.io_gcd_in_ready = 1'b1;
    tick();
    bus.io_gcd_in_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if ({bus.io_resp0_valid, bus.io_busy} !== 2'b01) begin
        n_bad++; $display("FAIL tmo_wait[%0d]: got v=%b busy=%b want 0 1",
          i, bus.io_resp0_valid, bus.io_busy);
      end
      tick();
    end
    n_cmp++;
    if ({bus.io_resp0_valid, bus.io_resp0_err, bus.io_busy} !== 3'b110 ||
        bus.io_resp0_bits !== 16'd0) begin
      n_bad++; $display("FAIL tmo_resp: got v=%b e=%b busy=%b d=%0d want 1 1 0 0",
        bus.io_resp0_valid, bus.io_resp0_err, bus.io_busy, bus.io_resp0_bits);
    end
    bus.io_resp0_ready = 1'b1;
    tick();
    bus.io_resp0_ready = 1'b0;
    bus.io_req0_valid  = 1'b1;
    bus.io_req0_bits_a = 16'd6;
    bus.io_req0_bits_b = 16'd4;
    tick();
    bus.io_req0_valid = 1'b0;
    engine(16'd2);
    n_cmp++;
    if (bus.io_resp0_err !== 1'b0 || bus.io_resp0_bits !== 16'd2) begin
      n_bad++; $display("FAIL tmo_after: got e=%b d=%0d want 0 2",
        bus.io_resp0_err, bus.io_resp0_bits);
    end
    bus.io_resp0_ready = 1'b1;
    tick();
    bus.io_resp0_ready = 1'b0;
  endtask
`else
  task automatic test_no_timeout();
    bus.io_req0_valid  = 1'b1;
    bus.io_req0_bits_a = 16'd5;
    bus.io_req0_bits_b = 16'd0;
    tick();
    bus.io_req0_valid   = 1'b0;
    bus.io_gcd_in_ready = 1'b1;
    tick();
    bus.io_gcd_in_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      n_cmp++;
      if ({bus.io_resp0_valid, bus.io_resp0_err, bus.io_busy} !== 3'b001) begin
        n_bad++; $display("FAIL wait_forever[%0d]: got v=%b e=%b busy=%b want 0 0 1",
          i, bus.io_resp0_valid, bus.io_resp0_err, bus.io_busy);
      end
      tick();
    end
    do_reset();
  endtask
`endif

  task automatic test_reset_wait();
    bus.io_req1_valid  = 1'b1;
    bus.io_req1_bits_a = 16'd8;
    bus.io_req1_bits_b = 16'd12;
    tick();
    bus.io_req1_valid = 1'b0;
    engine(16'd4);
    n_cmp++;
    if (bus.io_resp1_bits !== 16'd4) begin
      n_bad++; $display("FAIL rstw_pre: got %0d want 4", bus.io_resp1_bits);
    end
    bus.io_resp1_ready = 1'b1;
    tick();
    bus.io_resp1_ready = 1'b0;
    bus.io_req1_valid  = 1'b1;
    bus.io_req1_bits_a = 16'd9;
    bus.io_req1_bits_b = 16'd6;
    tick();
    bus.io_req1_valid   = 1'b0;
    bus.io_gcd_in_ready = 1'b1;
    tick();
    bus.io_gcd_in_ready = 1'b0;
    bus.io_req0_valid   = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({bus.io_busy, bus.io_gcd_in_valid, bus.io_req0_ready, bus.io_req1_ready} !== 4'b0) begin
      n_bad++; $display("FAIL rstw_async: got busy=%b iv=%b r0=%b r1=%b want 0000",
        bus.io_busy, bus.io_gcd_in_valid, bus.io_req0_ready, bus.io_req1_ready);
    end
    n_cmp++;
    if (bus.io_resp1_valid !== 1'b0 || bus.io_resp1_bits !== 16'd0) begin
      n_bad++; $display("FAIL rstw_resp: got v=%b d=%0d want 0 0",
        bus.io_resp1_valid, bus.io_resp1_bits);
    end
    bus.io_req0_valid = 1'b0;
    tick();
    reset = 1'b1;
    bus.io_gcd_out_valid = 1'b1;
    bus.io_gcd_out_bits  = 16'd3;
    tick();
    bus.io_gcd_out_valid = 1'b0;
    tick();
    n_cmp++;
    if ({bus.io_resp0_valid, bus.io_resp1_valid, bus.io_busy} !== 3'b000) begin
      n_bad++; $display("FAIL rstw_late: got r0v=%b r1v=%b busy=%b want 000",
        bus.io_resp0_valid, bus.io_resp1_valid, bus.io_busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_stall();
`ifdef GCD_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gcd_arbiter.md
GCD_ARBITER -- requirements
Module: gcd_arbiter

Interface
REQ-001 Parameter W, default 16, operand/result width in bits.
REQ-002 Parameter TIMEOUT_CYCLES, default 1023, WAIT-state cycles before abort (only with GCD_ARB_TIMEOUT_EN).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clock  in  1  sole clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 io_reqN_valid / io_reqN_ready  in / out  1  requester N (N=0,1) operand handshake.
REQ-007 io_reqN_bits_a, io_reqN_bits_b  in  W  requester N operands.
REQ-008 io_respN_valid / io_respN_ready  out / in  1  requester N result handshake.
REQ-009 io_respN_bits  out  W  result; io_respN_err  out  1  timeout flag.
REQ-010 io_gcd_in_valid  out  1; io_gcd_in_ready  in  1  engine operand handshake.
REQ-011 io_gcd_in_bits_a, io_gcd_in_bits_b  out  W  latched operands to engine.
REQ-012 io_gcd_out_valid  in  1  single-cycle result pulse; io_gcd_out_bits  in  W.
REQ-013 io_busy  out  1  high whenever state is not IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE and WAIT, with exactly one transaction outstanding at the engine.
REQ-015 Requester N SHALL be eligible when io_reqN_valid=1 and io_respN_valid=0.
REQ-016 In IDLE, io_reqN_ready SHALL equal (eligible N and grant N), combinationally; all other states drive ready=0.
REQ-017 Grant SHALL be round-robin: if both are eligible, the requester not served last wins; after reset, requester 0 wins.
REQ-018 On accept (valid&ready), the block SHALL latch a, b and owner, update the round-robin pointer, and enter ISSUE next cycle.
REQ-019 In ISSUE, io_gcd_in_valid=1 with latched operands; on io_gcd_in_ready=1, it SHALL go to WAIT next cycle.
REQ-020 In WAIT, io_gcd_out_valid=1 SHALL load io_gcd_out_bits into the owner's response register, set io_respN_valid=1, err=0, and return to IDLE.
REQ-021 io_respN_valid SHALL hold, with bits stable, until io_respN_ready=1; clear on that edge.
REQ-022 Response return and a new accept MAY occur in the same IDLE cycle for different requesters.
REQ-023 io_gcd_out_valid outside WAIT SHALL be ignored.
REQ-024 Minimum latency from accept to io_respN_valid SHALL be 2 cycles plus the engine latency.
REQ-025 Operands SHALL pass unmodified, including zero values; the block performs no arithmetic.

Reset
REQ-026 Reset SHALL force: state=IDLE, all valid/ready outputs 0, io_respN_bits 0, err 0, rr pointer to 0, timeout counter 0.
REQ-027 Reset asserted mid-transaction SHALL discard it without issuing a response.

Configuration
REQ-028 With GCD_ARB_TIMEOUT_EN defined, a counter SHALL run in WAIT; at TIMEOUT_CYCLES without io_gcd_out_valid, it SHALL return bits=0, err=1 to the owner and go to IDLE.
REQ-029 Without GCD_ARB_TIMEOUT_EN, WAIT SHALL persist indefinitely, with io_respN_err tied 0 and no counter logic.

Structure
REQ-030 Package gcd_arb_pkg SHALL hold the state enum, W default and TIMEOUT_CYCLES default.
REQ-031 Sub-module gcd_rr_arbiter SHALL implement the 2-way round-robin grant and pointer.

Verification
REQ-032 req0 a=48 b=32, engine returns 16 -> resp0_valid=1, bits=16, err=0; resp1 stays 0.
REQ-033 Same cycle: req0 (7,3) and req1 (100,10) -> req0 served first (1), then req1 (10); the pointer alternates.
REQ-034 resp0_ready=0 for 20 cycles with req0 re-asserted -> req0 not granted, and resp0 bits stay stable until ready.
REQ-035 Engine holds in_ready=0 for 5 cycles in ISSUE -> in_valid and operands stay stable, and busy=1 throughout.
REQ-036 GCD_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, engine silent -> err=1 and bits=0 after 8 WAIT cycles, then IDLE.
REQ-037 Reset asserted in WAIT -> outputs take reset values asynchronously; a later engine out_valid is ignored.
